mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported unified memory (32-bit word array, combinational read, byte-enabled synchronous write) between the instruction-fetch requester and the load/store requester. It grants at most one requester per cycle, drives the memory's address/write-data/write-enable lines from the winner, and returns read data through registered response ports one cycle later. It sits between the core's fetch and LSU stages and the memory instance.

## Interface

Parameters:
- `DATA_LOCK_MAX`, default 4: consecutive data grants allowed while fetch is waiting before fetch is forced through. Fixed-priority mode only. Legal range 1–15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `i_req`  in  1: fetch request; held with `i_addr` stable until `i_ready`.
- `i_addr`  in  32: fetch byte address.
- `i_ready`  out  1: fetch granted this cycle; combinational.
- `i_rvalid`  out  1: one-cycle pulse, fetch data valid.
- `i_rdata`  out  32: fetch read data; registered.
- `d_req`  in  1: load/store request; held with its payload stable until `d_ready`.
- `d_addr`  in  32: load/store byte address.
- `d_wdata`  in  32: store data.
- `d_wstrb`  in  4: byte strobes; 0 means read.
- `d_ready`  out  1: data request granted this cycle; combinational.
- `d_rvalid`  out  1: one-cycle pulse, load/store complete.
- `d_rdata`  out  32: load data; registered; 0 after a store.
- `mem_addr`  out  32: memory address.
- `mem_wdata`  out  32: memory write data.
- `mem_wenable`  out  4: memory byte write enables.
- `mem_rdata`  in  32: memory combinational read data, already shifted by byte offset.

## Operation

- Grant is combinational from `i_req`, `d_req` and registered arbitration state. At most one of `i_ready`/`d_ready` is high per cycle.
- Fetch granted: `mem_addr=i_addr`, `mem_wenable=0`.
- Data granted: `mem_addr=d_addr`, `mem_wdata=d_wdata`, `mem_wenable=d_wstrb`.
- No grant: `mem_addr=0`, `mem_wdata=0`, `mem_wenable=0`. A write never occurs without `d_ready`.
- Response capture on the edge ending a grant cycle:
  - Fetch: `i_rdata<=mem_rdata`; `i_rvalid<=1`.
  - Data read: `d_rdata<=mem_rdata`; `d_rvalid<=1`.
  - Data write: `d_rdata<=0`; `d_rvalid<=1`.
  - A non-granted port's rvalid goes 0. Its rdata holds its last value.
- Fixed-priority arbitration (default):
  - Data wins on conflict, except when `streak==DATA_LOCK_MAX`; then fetch wins.
  - `streak` is a 4-bit counter. It increments, saturating, on each data grant while `i_req` is high.
  - It clears on any fetch grant or any cycle with `i_req` low.
- Lone requester: granted the same cycle it asserts. Back-to-back grants to one port are allowed every cycle.
- Requesters must not drop `req` or change the payload before `ready`. Behaviour on violation is undefined.

## Timing

- Request to ready: 0 cycles if it wins. Ready to rvalid: 1 cycle. Sustained throughput: 1 access/cycle total.
- Store data is written on the same edge that captures `d_rvalid`.
- Reset values, applied asynchronously on `rst_n` low:
  - `i_rvalid=0`, `d_rvalid=0`, `i_rdata=0`, `d_rdata=0`.
  - `streak=0`, `last_grant=fetch`.
- While `rst_n` is low, `i_ready=0`, `d_ready=0`, `mem_wenable=0`, and `mem_addr`/`mem_wdata` are 0.
- Reset mid-operation drops any pending rvalid. No memory write occurs during reset.
- First grant possible in the first cycle after `rst_n` deasserts.

## Configuration

- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register updates on every grant.
  - On conflict, the port not granted last wins.
  - `streak` is held at 0 and `DATA_LOCK_MAX` is ignored.
- `MEM_ARB_RR_EN` undefined: fixed data priority with the `streak` anti-starvation rule above. `last_grant` is still maintained but does not affect grants.

## Test plan

- Lone fetch: memory word 0x10 = 0xDEADBEEF. `i_req=1`, `i_addr=0x40` -> `i_ready=1` same cycle; next cycle `i_rvalid=1`, `i_rdata=0xDEADBEEF`.
- Store then load: `d_wstrb=4'b0011`, `d_addr=0x80`, `d_wdata=0x0000A5A5` over old 0x11223344 -> `d_rvalid` pulse with `d_rdata=0`; load of 0x80 returns 0x1122A5A5.
- Conflict, fixed priority, `DATA_LOCK_MAX=4`, both `req` held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I… No cycle has both readies.
- Conflict with `MEM_ARB_RR_EN`, both `req` held from reset -> grants alternate D,I,D,I. The first grant is D because `last_grant` resets to fetch.
- Reset mid-access: assert `rst_n=0` in the cycle `d_ready=1` with `d_wstrb=4'hF` -> target word unchanged, `d_rvalid=0`, all outputs at reset values immediately, without waiting for a clock edge.
- Idle: no `req` for 10 cycles -> `mem_wenable=0`, `mem_addr=0`, both rvalid 0; `streak` stays 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported unified memory between the instruction-fetch
// requester and the load/store requester. At most one requester is granted
// per cycle. The winner drives the memory address, write-data and byte-enable
// lines, and its read data is returned through registered response ports one
// cycle later.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on conflict.
//                  undefined -> fixed data priority. Fetch is forced through
//                               once DATA_LOCK_MAX data grants have been made
//                               while fetch was waiting.
//
// Handshake: a requester raises req and holds its payload stable until it
// sees ready high in the same cycle. The access completes on that cycle's
// rising edge, and the matching rvalid pulses for exactly one cycle
// afterwards.

module mem_arbiter #(
    parameter int unsigned DATA_LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wenable,
    input  logic [31:0] mem_rdata
);

    // Encoding of the last_grant register.
    localparam logic LG_FETCH = 1'b0;
    localparam logic LG_DATA  = 1'b1;

    // Arbitration state.
    logic [3:0] streak;      // data grants made while fetch was waiting
    logic       last_grant;  // port that won the most recent grant

    logic       i_grant;
    logic       d_grant;
    logic       d_is_read;

    assign d_is_read = (d_wstrb == 4'b0000);

`ifndef MEM_ARB_RR_EN
    localparam logic [3:0] LOCK_LIMIT = 4'(DATA_LOCK_MAX);
`endif

    // Grant decision. It is gated by rst_n so nothing is granted while reset
    // is asserted.
    always_comb begin
        i_grant = 1'b0;
        d_grant = 1'b0;
        if (rst_n) begin
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                // On conflict, the port that was not granted last wins.
                if (last_grant == LG_DATA) begin
                    i_grant = 1'b1;
                end else begin
                    d_grant = 1'b1;
                end
`else
                // Data has priority unless fetch has waited out the lock limit.
                if (streak == LOCK_LIMIT) begin
                    i_grant = 1'b1;
                end else begin
                    d_grant = 1'b1;
                end
`endif
            end else begin
                i_grant = i_req;
                d_grant = d_req;
            end
        end
    end

    assign i_ready = i_grant;
    assign d_ready = d_grant;

    // Memory-side mux. The bus is idle (all zero) unless a port is granted.
    always_comb begin
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_wenable = 4'h0;
        if (i_grant) begin
            mem_addr = i_addr;
        end else if (d_grant) begin
            mem_addr    = d_addr;
            mem_wdata   = d_wdata;
            mem_wenable = d_wstrb;
        end
    end

    // Anti-starvation counter and last-grant tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak     <= 4'd0;
            last_grant <= LG_FETCH;
        end else begin
            if (i_grant) begin
                last_grant <= LG_FETCH;
            end else if (d_grant) begin
                last_grant <= LG_DATA;
            end
`ifdef MEM_ARB_RR_EN
            streak <= 4'd0;
`else
            if (i_grant || !i_req) begin
                streak <= 4'd0;
            end else if (d_grant && (streak != 4'hF)) begin
                streak <= streak + 4'd1;
            end
`endif
        end
    end

    // Response registers. Each rvalid pulses for one cycle after its grant.
    // Each rdata holds its last value when the port is not granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            i_rvalid <= i_grant;
            d_rvalid <= d_grant;
            if (i_grant) begin
                i_rdata <= mem_rdata;
            end
            if (d_grant) begin
                d_rdata <= d_is_read ? mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural memory, table-driven single-cycle
// vectors, and hand-written sequences for conflict, reset and idle behaviour.

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wenable;
    logic [31:0] mem_rdata;

    int errors;
    int checks;

    mem_arbiter #(.DATA_LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
        .mem_rdata(mem_rdata)
    );

    // Clock generation: 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, byte-enabled write on the edge.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wenable[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One table row holds the inputs for a single cycle, the expected
    // combinational outputs in that cycle, and the expected registered
    // outputs after the clock edge.
    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        e_ir;
        logic        e_dr;
        logic [31:0] e_ma;
        logic [31:0] e_mw;
        logic [3:0]  e_we;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;

        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h10] <= 32'hDEADBEEF;  // byte address 0x40
        mem[8'h20] <= 32'h11223344;  // byte address 0x80
        mem[8'h30] <= 32'hCAFEF00D;  // byte address 0xC0

        //          ir    ia          dr    da          dw            ds      e_ir  e_dr  e_ma        e_mw          e_we    e_irv e_ird         e_drv e_drd
        vecs[0] = '{1'b0, 32'h0,      1'b0, 32'h0,      32'h0,        4'h0,   1'b0, 1'b0, 32'h0,      32'h0,        4'h0,   1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h40,     1'b0, 32'h0,      32'h0,        4'h0,   1'b1, 1'b0, 32'h40,     32'h0,        4'h0,   1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,      1'b1, 32'h80,     32'h0000A5A5, 4'h3,   1'b0, 1'b1, 32'h80,     32'h0000A5A5, 4'h3,   1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0,      1'b1, 32'h80,     32'h0,        4'h0,   1'b0, 1'b1, 32'h80,     32'h0,        4'h0,   1'b0, 32'hDEADBEEF, 1'b1, 32'h1122A5A5};
        vecs[4] = '{1'b0, 32'h0,      1'b1, 32'h40,     32'h0,        4'h0,   1'b0, 1'b1, 32'h40,     32'h0,        4'h0,   1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{1'b1, 32'hC0,     1'b0, 32'h0,      32'h0,        4'h0,   1'b1, 1'b0, 32'hC0,     32'h0,        4'h0,   1'b1, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 32'h0,      1'b1, 32'hC0,     32'h12345678, 4'hF,   1'b0, 1'b1, 32'hC0,     32'h12345678, 4'hF,   1'b0, 32'hCAFEF00D, 1'b1, 32'h0};
        vecs[7] = '{1'b1, 32'hC0,     1'b0, 32'h0,      32'h0,        4'h0,   1'b1, 1'b0, 32'hC0,     32'h0,        4'h0,   1'b1, 32'h12345678, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0,      1'b1, 32'h100,    32'hAB000000, 4'h8,   1'b0, 1'b1, 32'h100,    32'hAB000000, 4'h8,   1'b0, 32'h12345678, 1'b1, 32'h0};
        vecs[9] = '{1'b0, 32'h0,      1'b1, 32'h100,    32'h0,        4'h0,   1'b0, 1'b1, 32'h100,    32'h0,        4'h0,   1'b0, 32'h12345678, 1'b1, 32'hAB000000};

        // Reset values.
        #3;
        chk("reset i_rvalid", {31'h0, i_rvalid}, 32'h0);
        chk("reset d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("reset i_rdata", i_rdata, 32'h0);
        chk("reset d_rdata", d_rdata, 32'h0);
        chk("reset streak", {28'h0, dut.streak}, 32'h0);
        chk("reset last_grant", {31'h0, dut.last_grant}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors.
        for (int n = 0; n < 10; n++) begin
            i_req = vecs[n].ir; i_addr = vecs[n].ia;
            d_req = vecs[n].dr; d_addr = vecs[n].da;
            d_wdata = vecs[n].dw; d_wstrb = vecs[n].ds;
            #1;
            chk($sformatf("v%0d i_ready", n), {31'h0, i_ready}, {31'h0, vecs[n].e_ir});
            chk($sformatf("v%0d d_ready", n), {31'h0, d_ready}, {31'h0, vecs[n].e_dr});
            chk($sformatf("v%0d mem_addr", n), mem_addr, vecs[n].e_ma);
            chk($sformatf("v%0d mem_wdata", n), mem_wdata, vecs[n].e_mw);
            chk($sformatf("v%0d mem_wenable", n), {28'h0, mem_wenable}, {28'h0, vecs[n].e_we});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d i_rvalid", n), {31'h0, i_rvalid}, {31'h0, vecs[n].e_irv});
            chk($sformatf("v%0d i_rdata", n), i_rdata, vecs[n].e_ird);
            chk($sformatf("v%0d d_rvalid", n), {31'h0, d_rvalid}, {31'h0, vecs[n].e_drv});
            chk($sformatf("v%0d d_rdata", n), d_rdata, vecs[n].e_drd);
            @(negedge clk);
        end

        // Reset asserted in the middle of a granted full-word store.
        i_req = 1'b0;
        d_req = 1'b1; d_addr = 32'hC0; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF;
        #1;
        chk("rst_mid d_ready before", {31'h0, d_ready}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid d_ready", {31'h0, d_ready}, 32'h0);
        chk("rst_mid i_ready", {31'h0, i_ready}, 32'h0);
        chk("rst_mid mem_wenable", {28'h0, mem_wenable}, 32'h0);
        chk("rst_mid mem_addr", mem_addr, 32'h0);
        chk("rst_mid mem_wdata", mem_wdata, 32'h0);
        chk("rst_mid d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("rst_mid i_rvalid", {31'h0, i_rvalid}, 32'h0);
        chk("rst_mid i_rdata", i_rdata, 32'h0);
        chk("rst_mid d_rdata", d_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid word unchanged", mem[8'h30], 32'h12345678);
        chk("rst_mid d_rvalid after edge", {31'h0, d_rvalid}, 32'h0);

        // Conflict: both requesters held from the first cycle after reset.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h80; d_wdata = 32'h0; d_wstrb = 4'h0;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            logic exp_d;
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);      // D,I,D,I,...
`else
            exp_d = (k % 5 != 4);      // D,D,D,D,I,...
`endif
            #1;
            chk($sformatf("conflict c%0d d_ready", k), {31'h0, d_ready}, {31'h0, exp_d});
            chk($sformatf("conflict c%0d i_ready", k), {31'h0, i_ready}, {31'h0, ~exp_d});
            @(negedge clk);
        end

        // Idle for 10 cycles.
        i_req = 1'b0; d_req = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("idle c%0d mem_wenable", k), {28'h0, mem_wenable}, 32'h0);
            chk($sformatf("idle c%0d mem_addr", k), mem_addr, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("idle c%0d i_rvalid", k), {31'h0, i_rvalid}, 32'h0);
            chk($sformatf("idle c%0d d_rvalid", k), {31'h0, d_rvalid}, 32'h0);
            chk($sformatf("idle c%0d streak", k), {28'h0, dut.streak}, 32'h0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
